// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_run_pkg : run-controller state encoding and signature helper
// rev 1.0
// ------------------------------------------------------------------
package cpu_run_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST_CORE = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    RST_CORE = ST_RST_CORE,
    RUN      = ST_RUN,
    CHECK    = ST_CHECK,
    DONE     = ST_DONE
  } run_state_t;

  localparam int RV_XLEN = 32;

  function automatic logic [RV_XLEN-1:0] rotl1(input logic [RV_XLEN-1:0] v);
    return {v[RV_XLEN-2:0], v[RV_XLEN-1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_history_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// pc_history_buf : circular write-only PC buffer, read relative to newest
// rev 1.0
// ------------------------------------------------------------------
module pc_history_buf #(
  parameter int XLEN       = 32,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [XLEN-1:0]               wr_data,
  input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]               rd_data
);

  localparam int IDX_W = $clog2(HIST_DEPTH);

  logic [XLEN-1:0]  mem_q [HIST_DEPTH];
  logic [XLEN-1:0]  mem_d [HIST_DEPTH];
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] rd_addr;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (wr_en) begin
      mem_d[ptr_q] = wr_data;
      ptr_d        = ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

  // Depth is a power of two, so the modulo falls out of the pointer width.
  assign rd_addr = ptr_q - IDX_W'(1) - rd_idx;
  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_run_monitor : core reset sequencer, write-back signature, halt/timeout checker
// rev 1.0
// ------------------------------------------------------------------
module cpu_run_monitor
  import cpu_run_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 16,
  parameter int              RST_CYCLES  = 2,
  parameter int              MAX_CYCLES  = 1024,
  parameter int              HALT_CYCLES = 4,
  parameter int              HIST_DEPTH  = 8,
  parameter logic [XLEN-1:0] SIG_SEED    = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [XLEN-1:0]               expected_sig,
  input  logic [CNT_W-1:0]              expected_wr_cnt,
  input  logic [XLEN-1:0]               pc_addr,
  input  logic                          reg_write,
  input  logic [XLEN-1:0]               wb_data,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic                          core_reset_n,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [CNT_W-1:0]              wr_cnt,
  output logic [XLEN-1:0]               signature,
  output logic [XLEN-1:0]               hist_pc
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int STB_W = $clog2(HALT_CYCLES + 1);

  run_state_t       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             core_reset_n_q, core_reset_n_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [XLEN-1:0]  sig_q, sig_d;
  logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
  logic             pc_prev_vld_q, pc_prev_vld_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic             hist_wr;
  logic             hist_clr;
  logic             pc_match;
  logic [XLEN-1:0]  sig_rot;

  generate
    if (XLEN == RV_XLEN) begin : g_rotl_pkg
      assign sig_rot = rotl1(sig_q);
    end else begin : g_rotl_generic
      assign sig_rot = {sig_q[XLEN-2:0], sig_q[XLEN-1]};
    end
  endgenerate

  // The first RUN cycle has no previous PC, so it can never count as unchanged.
  assign pc_match = pc_prev_vld_q && (pc_addr == pc_prev_q);

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    core_reset_n_d = core_reset_n_q;
    cycle_cnt_d    = cycle_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    sig_d          = sig_q;
    pc_prev_d      = pc_prev_q;
    pc_prev_vld_d  = pc_prev_vld_q;
    stable_d       = stable_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    hist_wr        = 1'b0;
    hist_clr       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = RST_CORE;
          rst_cnt_d      = '0;
          core_reset_n_d = 1'b0;
          cycle_cnt_d    = '0;
          wr_cnt_d       = '0;
          sig_d          = SIG_SEED;
          pc_prev_vld_d  = 1'b0;
          stable_d       = '0;
          pass_d         = 1'b0;
          timeout_d      = 1'b0;
          hist_clr       = 1'b1;
        end
      end
      RST_CORE: begin
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
          state_d        = RUN;
          core_reset_n_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      RUN: begin
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        hist_wr       = 1'b1;
        pc_prev_d     = pc_addr;
        pc_prev_vld_d = 1'b1;
        stable_d      = pc_match ? stable_q + STB_W'(1) : '0;
        if (reg_write) begin
          sig_d = sig_rot ^ wb_data;
          if (wr_cnt_q != '1) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
        // Halt is tested first so it wins when it lands on the last allowed cycle.
        if (pc_match && (stable_q == STB_W'(HALT_CYCLES - 1))) begin
          state_d = CHECK;
        end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = CHECK;
          timeout_d = 1'b1;
        end
      end
      CHECK: begin
        pass_d         = !timeout_q && (sig_q == expected_sig) && (wr_cnt_q == expected_wr_cnt);
        core_reset_n_d = 1'b0;
        state_d        = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rst_cnt_q      <= '0;
      core_reset_n_q <= 1'b0;
      cycle_cnt_q    <= '0;
      wr_cnt_q       <= '0;
      sig_q          <= SIG_SEED;
      pc_prev_q      <= '0;
      pc_prev_vld_q  <= 1'b0;
      stable_q       <= '0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      core_reset_n_q <= core_reset_n_d;
      cycle_cnt_q    <= cycle_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      sig_q          <= sig_d;
      pc_prev_q      <= pc_prev_d;
      pc_prev_vld_q  <= pc_prev_vld_d;
      stable_q       <= stable_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
    end
  end

  // Restarting a run also wipes old history entries, which read back as zero.
  pc_history_buf #(
    .XLEN       (XLEN),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .reset   (reset | hist_clr),
    .wr_en   (hist_wr),
    .wr_data (pc_addr),
    .rd_idx  (hist_idx),
    .rd_data (hist_pc)
  );

  assign core_reset_n = core_reset_n_q;
  assign busy         = (state_q == RST_CORE) || (state_q == RUN) || (state_q == CHECK);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign wr_cnt       = wr_cnt_q;
  assign signature    = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cpu_run_monitor : directed runs, scoreboard of probes and end-of-run results
// rev 1.0
// ------------------------------------------------------------------
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] expected_sig;
  logic [15:0] expected_wr_cnt;
  logic [31:0] pc_addr;
  logic        reg_write;
  logic [31:0] wb_data;
  logic [2:0]  hist_idx;
  logic        core_reset_n;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] cycle_cnt;
  logic [15:0] wr_cnt;
  logic [31:0] signature;
  logic [31:0] hist_pc;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .XLEN        (32),
    .CNT_W       (16),
    .RST_CYCLES  (2),
    .MAX_CYCLES  (16),
    .HALT_CYCLES (4),
    .HIST_DEPTH  (8),
    .SIG_SEED    (32'hFFFF_FFFF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .expected_sig    (expected_sig),
    .expected_wr_cnt (expected_wr_cnt),
    .pc_addr         (pc_addr),
    .reg_write       (reg_write),
    .wb_data         (wb_data),
    .hist_idx        (hist_idx),
    .core_reset_n    (core_reset_n),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .cycle_cnt       (cycle_cnt),
    .wr_cnt          (wr_cnt),
    .signature       (signature),
    .hist_pc         (hist_pc)
  );

  typedef enum int {F_CRN, F_BUSY, F_DONE, F_PASS, F_TO, F_CYC, F_WR, F_SIG, F_HIST} field_t;
  typedef struct {
    string       name;
    field_t      f;
    logic [31:0] val;
  } probe_t;
  typedef struct {
    string       name;
    logic        pass;
    logic        timeout;
    logic [31:0] sig;
    logic [15:0] wr;
    logic [15:0] cyc;
  } result_t;

  probe_t  probe_q[$];
  result_t result_q[$];
  int      checks = 0;
  int      errors = 0;
  event    probe_ev;
  logic    done_prev = 1'b0;
  probe_t  mon_p;
  result_t mon_r;

  function automatic logic [31:0] read_field(input field_t f);
    case (f)
      F_CRN:   return {31'd0, core_reset_n};
      F_BUSY:  return {31'd0, busy};
      F_DONE:  return {31'd0, done};
      F_PASS:  return {31'd0, pass};
      F_TO:    return {31'd0, timeout};
      F_CYC:   return {16'd0, cycle_cnt};
      F_WR:    return {16'd0, wr_cnt};
      F_SIG:   return signature;
      F_HIST:  return hist_pc;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Probe monitor: drains queued point expectations when the stimulus asks.
  initial begin
    forever begin
      @(probe_ev);
      while (probe_q.size() > 0) begin
        mon_p = probe_q.pop_front();
        compare(mon_p.name, read_field(mon_p.f), mon_p.val);
      end
    end
  end

  // Result monitor: a new done presents the outcome of the oldest pending run.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (result_q.size() == 0) begin
        compare("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_r = result_q.pop_front();
        compare({mon_r.name, "_pass"},    {31'd0, pass},    {31'd0, mon_r.pass});
        compare({mon_r.name, "_timeout"}, {31'd0, timeout}, {31'd0, mon_r.timeout});
        compare({mon_r.name, "_sig"},     signature,        mon_r.sig);
        compare({mon_r.name, "_wr_cnt"},  {16'd0, wr_cnt},  {16'd0, mon_r.wr});
        compare({mon_r.name, "_cycles"},  {16'd0, cycle_cnt}, {16'd0, mon_r.cyc});
      end
    end
    done_prev <= done;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_f(input string name, input field_t f, input logic [31:0] v);
    probe_t p;
    p.name = name;
    p.f    = f;
    p.val  = v;
    probe_q.push_back(p);
  endtask

  task automatic probe();
    ->probe_ev;
    #1;
  endtask

  task automatic expect_result(input string name, input logic ps, input logic to,
                               input logic [31:0] sig, input logic [15:0] wr, input logic [15:0] cyc);
    result_t r;
    r.name    = name;
    r.pass    = ps;
    r.timeout = to;
    r.sig     = sig;
    r.wr      = wr;
    r.cyc     = cyc;
    result_q.push_back(r);
  endtask

  task automatic drive_cycle(input logic [31:0] pc, input logic we, input logic [31:0] wb);
    pc_addr   = pc;
    reg_write = we;
    wb_data   = wb;
    tick();
  endtask

  // Leaves the bench in the first RUN cycle, inputs not yet sampled.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_f("start_busy", F_BUSY, 32'd1);
    expect_f("start_done_clr", F_DONE, 32'd0);
    expect_f("start_pass_clr", F_PASS, 32'd0);
    expect_f("start_timeout_clr", F_TO, 32'd0);
    expect_f("start_core_rst_low", F_CRN, 32'd0);
    probe();
    tick();
    expect_f("rst2_core_rst_low", F_CRN, 32'd0);
    expect_f("rst2_busy", F_BUSY, 32'd1);
    probe();
    tick();
    expect_f("run_core_rst_high", F_CRN, 32'd1);
    expect_f("run_cycle_cnt0", F_CYC, 32'd0);
    expect_f("run_sig_seed", F_SIG, 32'hFFFF_FFFF);
    probe();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      compare({name, "_done_wait"}, 32'd0, 32'd1);
      if (result_q.size() > 0) result_q.delete(0);
    end else begin
      expect_f({name, "_idle_busy"}, F_BUSY, 32'd0);
      expect_f({name, "_frozen_core"}, F_CRN, 32'd0);
      probe();
    end
  endtask

  // Writes 0x5 then 0x3: FFFFFFFF -> FFFFFFFA -> FFFFFFF6; halt after 4 unchanged PCs at 0x8.
  task automatic halt_run(input string name, input logic [31:0] exp_sig, input logic exp_pass);
    expected_sig    = exp_sig;
    expected_wr_cnt = 16'd2;
    expect_result(name, exp_pass, 1'b0, 32'hFFFF_FFF6, 16'd2, 16'd7);
    start_run();
    drive_cycle(32'h0, 1'b1, 32'h5);
    expect_f({name, "_sig1"}, F_SIG, 32'hFFFF_FFFA);
    expect_f({name, "_wr1"}, F_WR, 32'd1);
    expect_f({name, "_cyc1"}, F_CYC, 32'd1);
    probe();
    drive_cycle(32'h4, 1'b1, 32'h3);
    expect_f({name, "_sig2"}, F_SIG, 32'hFFFF_FFF6);
    expect_f({name, "_wr2"}, F_WR, 32'd2);
    probe();
    drive_cycle(32'h8, 1'b0, 32'h0);
    start = 1'b1;
    drive_cycle(32'h8, 1'b0, 32'h0);
    start = 1'b0;
    wait_done(name, 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got no end, want end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    pc_addr         = '0;
    reg_write       = 1'b0;
    wb_data         = '0;
    hist_idx        = '0;
    expected_sig    = '0;
    expected_wr_cnt = '0;

    repeat (3) tick();
    expect_f("reset_core_rst", F_CRN, 32'd0);
    expect_f("reset_busy", F_BUSY, 32'd0);
    expect_f("reset_done", F_DONE, 32'd0);
    expect_f("reset_pass", F_PASS, 32'd0);
    expect_f("reset_timeout", F_TO, 32'd0);
    expect_f("reset_sig", F_SIG, 32'hFFFF_FFFF);
    expect_f("reset_cycle_cnt", F_CYC, 32'd0);
    expect_f("reset_wr_cnt", F_WR, 32'd0);
    expect_f("reset_hist", F_HIST, 32'd0);
    probe();
    reset = 1'b0;
    tick();

    halt_run("halt_pass", 32'hFFFF_FFF6, 1'b1);
    halt_run("halt_sig_off", 32'hFFFF_FFF7, 1'b0);

    // PC never settles: timeout after the 16th RUN cycle, pass forced low.
    expected_sig    = 32'hFFFF_FFFF;
    expected_wr_cnt = 16'd0;
    expect_result("timeout", 1'b0, 1'b1, 32'hFFFF_FFFF, 16'd0, 16'd16);
    start_run();
    for (int i = 0; i < 16; i++) drive_cycle(32'(4 * i), 1'b0, 32'h0);
    wait_done("timeout", 8);

    // PC settles at cycle 12 so the halt lands exactly on the 16th cycle.
    expect_result("halt_at_limit", 1'b1, 1'b0, 32'hFFFF_FFFF, 16'd0, 16'd16);
    start_run();
    for (int i = 0; i < 11; i++) drive_cycle(32'(4 * i), 1'b0, 32'h0);
    repeat (5) drive_cycle(32'h2C, 1'b0, 32'h0);
    wait_done("halt_at_limit", 8);

    start_run();
    for (int i = 0; i < 10; i++) drive_cycle(32'(4 * i), 1'b1, 32'(4 * i));
    hist_idx = 3'd0;
    #1;
    expect_f("hist_idx0", F_HIST, 32'h24);
    expect_f("hist_wr_cnt", F_WR, 32'd10);
    expect_f("hist_cycle_cnt", F_CYC, 32'd10);
    probe();
    hist_idx = 3'd7;
    #1;
    expect_f("hist_idx7", F_HIST, 32'h08);
    probe();
    hist_idx = 3'd3;
    #1;
    expect_f("hist_idx3", F_HIST, 32'h18);
    probe();
    hist_idx = 3'd0;

    reset = 1'b1;
    tick();
    expect_f("midrun_reset_busy", F_BUSY, 32'd0);
    expect_f("midrun_reset_done", F_DONE, 32'd0);
    expect_f("midrun_reset_core_rst", F_CRN, 32'd0);
    expect_f("midrun_reset_cycle_cnt", F_CYC, 32'd0);
    expect_f("midrun_reset_wr_cnt", F_WR, 32'd0);
    expect_f("midrun_reset_sig", F_SIG, 32'hFFFF_FFFF);
    expect_f("midrun_reset_hist", F_HIST, 32'd0);
    probe();
    reset = 1'b0;
    tick();
    tick();
    expect_f("idle_after_reset_busy", F_BUSY, 32'd0);
    expect_f("idle_after_reset_done", F_DONE, 32'd0);
    probe();

    compare("pending_results", 32'(result_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
